// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared definitions for the snoop bus arbiter: bus word layout, op codes, FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package snoop_pkg;

  localparam int BUS_W = 11;

  // Bus word field positions
  localparam int WB_BIT  = 10;
  localparam int ID_HI   = 9;
  localparam int ID_LO   = 8;
  localparam int RSV_HI  = 7;
  localparam int RSV_LO  = 6;
  localparam int OP_HI   = 5;
  localparam int OP_LO   = 4;
  localparam int TAG_BIT = 3;
  localparam int DATA_HI = 2;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    OP_NONE       = 2'b00,
    OP_READMISS   = 2'b01,
    OP_INVALIDATE = 2'b10,
    OP_RETURN     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETURN
  } state_e;

  // Only readmiss and invalidate may be placed on the bus by a cache.
  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_READMISS) || (op == OP_INVALIDATE);
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Snoop bus bundle between the caches/memory side and the arbiter.
// Ports: req/req_word/mem_in flow into the arbiter (slave); gnt/bus_out/done/err_timeout flow out.
// Backpressure: none; requests are level signals held until granted.
interface snoop_bus_arbiter_if #(parameter int NREQ = 4);
  import snoop_pkg::*;

  logic [NREQ-1:0]       req;
  logic [BUS_W*NREQ-1:0] req_word;
  logic [BUS_W-1:0]      mem_in;
  logic [NREQ-1:0]       gnt;
  logic [BUS_W-1:0]      bus_out;
  logic                  done;
  logic                  err_timeout;

  modport slave (
    input  req, req_word, mem_in,
    output gnt, bus_out, done, err_timeout
  );

  modport master (
    output req, req_word, mem_in,
    input  gnt, bus_out, done, err_timeout
  );

endinterface

// File: rtl/snoop_bus_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit searching upward from last+1 (mod NREQ).
// Ports: req, last in; one-hot pick and valid out. Latency: combinational.
// Backpressure: none.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    // k walks the priority order; the inner compare keeps every select constant.
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!valid && req[i] && (i == ((int'(last) + k) % NREQ))) begin
          pick[i] = 1'b1;
          valid   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter/sequencer: grants one cache, broadcasts its word, relays memory return.
// Ports: clk, rst_n (sync, active-low), bus (slave modport). Latency: grant/bus one cycle after req sample.
// Backpressure: one transaction at a time; req is only sampled in IDLE, read miss aborts after TIMEOUT.
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  snoop_bus_arbiter_if.slave  bus
);

  state_e           state;
  op_e              cur_op;
  logic [1:0]       last;
  logic [1:0]       winner;
  logic [3:0]       cnt;
  logic [NREQ-1:0]  gnt_r;
  logic [BUS_W-1:0] bus_r;
  logic             done_r;
  logic             err_r;

  logic [NREQ-1:0]  pick;
  logic             pick_vld;
  logic [1:0]       win_idx;
  logic [BUS_W-1:0] win_word;
  logic [BUS_W-1:0] fwd_word;
  logic             ret_match;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .last  (last),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    win_idx  = '0;
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        win_idx  = 2'(i);
        win_word = bus.req_word[i*BUS_W +: BUS_W];
      end
    end
  end

  // The id field always reflects who actually won, whatever the cache put there.
  assign fwd_word  = {win_word[WB_BIT], win_idx, win_word[RSV_HI:DATA_LO]};
  assign ret_match = (bus.mem_in[OP_HI:OP_LO] == OP_RETURN) &&
                     (bus.mem_in[ID_HI:ID_LO] == winner);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cur_op <= OP_NONE;
      last   <= 2'(NREQ - 1);
      winner <= '0;
      cnt    <= '0;
      gnt_r  <= '0;
      bus_r  <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          gnt_r <= '0;
          bus_r <= '0;
          if (pick_vld) begin
            last   <= win_idx;
            winner <= win_idx;
            cur_op <= op_e'(fwd_word[OP_HI:OP_LO]);
            if (op_legal(fwd_word[OP_HI:OP_LO])) begin
              state <= S_ISSUE;
              gnt_r <= pick;
              bus_r <= fwd_word;
            end else begin
              // Illegal op: retire immediately without touching the bus.
              done_r <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          bus_r <= '0;
          if (cur_op == OP_READMISS) begin
            state <= S_WAIT;
            cnt   <= '0;
          end else begin
            state  <= S_IDLE;
            gnt_r  <= '0;
            done_r <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 4'd1;
          if (ret_match) begin
            state <= S_RETURN;
            bus_r <= bus.mem_in;
          end else if (cnt == 4'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th wait cycle with no matching return.
            state  <= S_IDLE;
            gnt_r  <= '0;
            done_r <= 1'b1;
            err_r  <= 1'b1;
          end
        end
        S_RETURN: begin
          state  <= S_IDLE;
          gnt_r  <= '0;
          bus_r  <= '0;
          done_r <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.bus_out     = bus_r;
  assign bus.done        = done_r;
  assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: directed scenarios with literal expectations, then random traffic.
// A transaction-level model predicts gnt/bus_out/done/err_timeout for every cycle.
module tb_snoop_bus_arbiter;
  import snoop_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_bus_arbiter_if #(.NREQ(NREQ)) sif ();

  snoop_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Model: which phase of a transaction we are in (0 free, 1 issued, 2 awaiting memory, 3 relaying).
  int m_phase  = 0;
  int m_last   = NREQ - 1;
  int m_win    = 0;
  int m_op     = 0;
  int m_waited = 0;
  logic [NREQ-1:0] e_gnt  = '0;
  logic [10:0]     e_bus  = '0;
  logic            e_done = 1'b0;
  logic            e_err  = 1'b0;

  always @(posedge clk) begin
    logic [10:0] w;
    logic [10:0] m;
    int c;
    bit found;
    m      = sif.mem_in;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (!rst_n) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      e_gnt   = '0;
      e_bus   = '0;
    end else if (m_phase == 0) begin
      e_gnt = '0;
      e_bus = '0;
      if (sif.req != '0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (!found && sif.req[c[1:0]]) begin
            m_win = c;
            found = 1'b1;
          end
        end
        w       = sif.req_word[m_win*11 +: 11];
        w[9:8]  = 2'(m_win);
        m_last  = m_win;
        m_op    = int'(w[5:4]);
        if (m_op == 1 || m_op == 2) begin
          m_phase = 1;
          e_gnt[m_win[1:0]] = 1'b1;
          e_bus   = w;
        end else begin
          e_done = 1'b1;
        end
      end
    end else if (m_phase == 1) begin
      e_bus = '0;
      if (m_op == 1) begin
        m_phase  = 2;
        m_waited = 0;
      end else begin
        m_phase = 0;
        e_gnt   = '0;
        e_done  = 1'b1;
      end
    end else if (m_phase == 2) begin
      m_waited++;
      if (m[5:4] == 2'b11 && m[9:8] == 2'(m_win)) begin
        m_phase = 3;
        e_bus   = m;
      end else if (m_waited == TIMEOUT) begin
        m_phase = 0;
        e_gnt   = '0;
        e_done  = 1'b1;
        e_err   = 1'b1;
      end
    end else begin
      m_phase = 0;
      e_gnt   = '0;
      e_bus   = '0;
      e_done  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (sif.gnt !== e_gnt || sif.bus_out !== e_bus ||
          sif.done !== e_done || sif.err_timeout !== e_err) begin
        miscompares++;
        $display("FAIL model t=%0t got gnt=%b bus=%h done=%b err=%b want gnt=%b bus=%h done=%b err=%b",
                 $time, sif.gnt, sif.bus_out, sif.done, sif.err_timeout,
                 e_gnt, e_bus, e_done, e_err);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_all_words(input logic [10:0] w);
    for (int i = 0; i < NREQ; i++) sif.req_word[i*11 +: 11] = w;
  endtask

  initial begin
    logic [10:0] mw;
    int r;
    sif.req      = '0;
    sif.req_word = '0;
    sif.mem_in   = '0;
    rst_n        = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    lit("reset gnt", 32'(sif.gnt), 32'h0);
    lit("reset bus", 32'(sif.bus_out), 32'h0);
    lit("reset done/err", {30'd0, sif.done, sif.err_timeout}, 32'h0);
    rst_n = 1'b1;

    // Round-robin with all four requesting invalidates
    sif.req = '1;
    set_all_words(11'h020);
    for (int t = 0; t < 5; t++) begin
      tick();
      lit("rr gnt", 32'(sif.gnt), 32'(1 << (t % 4)));
      lit("rr id", 32'(sif.bus_out[9:8]), 32'(t % 4));
      if (t == 4) sif.req = '0;
      tick();
      lit("rr done", 32'(sif.done), 32'h1);
    end

    // Single readmiss from requester 2
    sif.req = 4'b0100;
    sif.req_word[22 +: 11] = 11'h010;
    tick();
    lit("rm gnt", 32'(sif.gnt), 32'h4);
    lit("rm issue bus", 32'(sif.bus_out), 32'h210);
    lit("model rm issue bus", 32'(e_bus), 32'h210);
    sif.req    = '0;
    sif.mem_in = 11'h231;
    tick();
    lit("rm wait bus", 32'(sif.bus_out), 32'h0);
    tick();
    lit("rm return bus", 32'(sif.bus_out), 32'h231);
    lit("rm return gnt", 32'(sif.gnt), 32'h4);
    sif.mem_in = '0;
    tick();
    lit("rm done", 32'(sif.done), 32'h1);
    lit("rm gnt clear", 32'(sif.gnt), 32'h0);

    // Invalidate from requester 1, with a bogus id the arbiter must overwrite
    sif.req = 4'b0010;
    sif.req_word[11 +: 11] = 11'h320;
    tick();
    lit("inv bus", 32'(sif.bus_out), 32'h120);
    lit("inv gnt", 32'(sif.gnt), 32'h2);
    sif.req = '0;
    tick();
    lit("inv done", 32'(sif.done), 32'h1);
    lit("inv bus idle", 32'(sif.bus_out), 32'h0);

    // Timeout: requester 0 readmiss, memory silent
    sif.req = 4'b0001;
    sif.req_word[0 +: 11] = 11'h010;
    tick();
    lit("to gnt", 32'(sif.gnt), 32'h1);
    sif.req = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      lit("to waiting", {26'd0, sif.done, sif.err_timeout, sif.gnt}, {26'd0, 6'b000001});
    end
    tick();
    lit("to pulse", {26'd0, sif.done, sif.err_timeout, sif.gnt}, {26'd0, 6'b110000});
    lit("model to pulse", {30'd0, e_done, e_err}, 32'h3);
    tick();
    lit("to one cycle", {30'd0, sif.done, sif.err_timeout}, 32'h0);

    // Mismatched return id is ignored
    sif.req = 4'b0001;
    tick();
    lit("mm gnt", 32'(sif.gnt), 32'h1);
    sif.req    = '0;
    sif.mem_in = 11'h331;
    tick();
    tick();
    lit("mm ignored", {17'd0, sif.gnt, sif.bus_out}, {17'd0, 4'b0001, 11'h000});
    sif.mem_in = 11'h035;
    tick();
    lit("mm return bus", 32'(sif.bus_out), 32'h035);
    lit("model mm return bus", 32'(e_bus), 32'h035);
    sif.mem_in = '0;
    tick();
    lit("mm done", {30'd0, sif.done, sif.err_timeout}, 32'h2);

    // Reset during WAIT of requester 1
    sif.req = 4'b0010;
    sif.req_word[11 +: 11] = 11'h010;
    tick();
    lit("rw gnt", 32'(sif.gnt), 32'h2);
    sif.req = '0;
    tick();
    rst_n = 1'b0;
    tick();
    lit("rw all zero", {17'd0, sif.gnt, sif.bus_out}, 32'h0);
    lit("rw no done", {30'd0, sif.done, sif.err_timeout}, 32'h0);
    rst_n   = 1'b1;
    sif.req = '1;
    set_all_words(11'h020);
    tick();
    lit("rw next grant", 32'(sif.gnt), 32'h1);
    sif.req = '0;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sif.req = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
      for (int i = 0; i < NREQ; i++) sif.req_word[i*11 +: 11] = 11'($urandom);
      r  = $urandom_range(0, 9);
      mw = 11'($urandom);
      if (r < 4) begin
        mw = '0;
      end else if (r < 7) begin
        mw[9:8] = 2'(m_win);
        mw[5:4] = 2'b11;
      end else if (r < 8) begin
        mw[9:8] = 2'((m_win + 1) % NREQ);
        mw[5:4] = 2'b11;
      end
      sif.mem_in = mw;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
